// File: rtl/bridge_ctrl_if.sv
// Processor/device bus bundle for bridge_ctrl. The slave modport is the bridge; the master
// modport is the environment (processor plus attached devices).
interface bridge_ctrl_if #(
  parameter int unsigned DEV_COUNT   = 3,
  parameter int unsigned DEV_ADDR_WD = 8,
  parameter int unsigned DATA_WD     = 32
);
  logic                         PrReq;
  logic                         PrWE;
  logic [31:0]                  PrAddr;
  logic [DATA_WD-1:0]           PrWD;
  logic [DATA_WD-1:0]           PrRD;
  logic                         PrAck;
  logic                         PrErr;
  logic [DEV_ADDR_WD-1:0]       DevAddr;
  logic [DATA_WD-1:0]           DevWD;
  logic [DEV_COUNT-1:0]         DevSel;
  logic [DEV_COUNT-1:0]         DevWE;
  logic [DEV_COUNT*DATA_WD-1:0] DevRD;
  logic [DEV_COUNT-1:0]         DevReady;
  logic [DEV_COUNT-1:0]         DevIrq;
  logic [DEV_COUNT-1:0]         HWInt;

  modport master (
    output PrReq, PrWE, PrAddr, PrWD, DevRD, DevReady, DevIrq,
    input  PrRD, PrAck, PrErr, DevAddr, DevWD, DevSel, DevWE, HWInt
  );

  modport slave (
    input  PrReq, PrWE, PrAddr, PrWD, DevRD, DevReady, DevIrq,
    output PrRD, PrAck, PrErr, DevAddr, DevWD, DevSel, DevWE, HWInt
  );
endinterface

// File: rtl/bridge_ctrl.sv
// Registered processor/device bridge: one outstanding request, one-hot device select, IRQ stage.
// Define BRIDGE_TIMEOUT_EN to abort an access after TIMEOUT cycles without device ready.
module bridge_ctrl #(
  parameter int unsigned DEV_COUNT   = 3,
  parameter int unsigned DEV_ID_WD   = 4,
  parameter int unsigned DEV_ADDR_WD = 8,
  parameter int unsigned DATA_WD     = 32
`ifdef BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 16
`endif
) (
  input logic          clk,
  input logic          reset,
  bridge_ctrl_if.slave bus
);
  localparam int unsigned IdLsb = DEV_ADDR_WD;
  localparam int unsigned IdMsb = DEV_ADDR_WD + DEV_ID_WD - 1;
  localparam int unsigned DecWd = DEV_ADDR_WD + DEV_ID_WD;

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  state_e                 state_q, state_d;
  logic [DEV_COUNT-1:0]   sel_q, sel_d, dwe_q, dwe_d, hwint_q;
  logic [DEV_ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0]     wd_q, wd_d, rd_q, rd_d, rd_mux;
  logic                   wr_q, wr_d, ack_q, ack_d, err_q, err_d;
  logic [DEV_ID_WD-1:0]   req_id;
  logic [DEV_COUNT-1:0]   req_onehot;
  logic                   dec_ok, dev_ready, timed_out;

  assign req_id = bus.PrAddr[IdMsb:IdLsb];
  assign dec_ok = ((bus.PrAddr >> DecWd) == 32'd0) && (32'(req_id) < DEV_COUNT);

  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < DEV_COUNT; i++) begin
      req_onehot[i] = (32'(req_id) == i);
    end
  end

  // sel_q is one-hot while in ACCESS, so it doubles as the read-data mux select.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < DEV_COUNT; i++) begin
      rd_mux = rd_mux | ({DATA_WD{sel_q[i]}} & bus.DevRD[i*DATA_WD +: DATA_WD]);
    end
  end

  assign dev_ready = |(bus.DevReady & sel_q);

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CntWd = $clog2(TIMEOUT + 1);
  logic [CntWd-1:0] cnt_q, cnt_d;

  assign cnt_d     = (state_q == StAccess && !dev_ready) ? cnt_q + CntWd'(1) : '0;
  // Checked only when ready is low, so ready on the final cycle still completes normally.
  assign timed_out = (cnt_q == CntWd'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwe_d   = dwe_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    rd_d    = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.PrReq) begin
          if (dec_ok) begin
            state_d = StAccess;
            sel_d   = req_onehot;
            dwe_d   = bus.PrWE ? req_onehot : '0;
            addr_d  = bus.PrAddr[DEV_ADDR_WD-1:0];
            wd_d    = bus.PrWD;
            wr_d    = bus.PrWE;
          end else begin
            state_d = StErr;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StAccess: begin
        if (dev_ready) begin
          state_d = StDone;
          sel_d   = '0;
          dwe_d   = '0;
          ack_d   = 1'b1;
          rd_d    = wr_q ? '0 : rd_mux;
        end else if (timed_out) begin
          state_d = StErr;
          sel_d   = '0;
          dwe_d   = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      dwe_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      hwint_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwe_q   <= dwe_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      hwint_q <= bus.DevIrq;
    end
  end

  assign bus.PrRD    = rd_q;
  assign bus.PrAck   = ack_q;
  assign bus.PrErr   = err_q;
  assign bus.DevAddr = addr_q;
  assign bus.DevWD   = wd_q;
  assign bus.DevSel  = sel_q;
  assign bus.DevWE   = dwe_q;
  assign bus.HWInt   = hwint_q;
endmodule

// File: doc/bridge_ctrl.md
Name: bridge_ctrl

Overview:
Parametrised, registered successor to the combinational processor/device bridge. It decodes a device ID field from PrAddr and runs a one-outstanding-transaction request/ack handshake towards the processor. Towards the selected device it drives a one-hot select/write-enable, and waits for per-device ready. It also aggregates device interrupt lines into a registered HWInt vector for the CP0 side.

Parameters:
DEV_COUNT, 3, number of attached devices (TC=0, IN32=1, OUT32=2 by codebase ID assignment)
DEV_ID_WD, 4, width of device ID field in PrAddr
DEV_ADDR_WD, 8, width of per-device offset field (PrAddr[DEV_ADDR_WD-1:0])
DATA_WD, 32, data bus width
TIMEOUT, 16, cycles in ACCESS before abort (only with BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
PrReq  in  1  processor request, held until PrAck
PrWE  in  1  1=write, 0=read; sampled with PrReq
PrAddr  in  32  ID field [DEV_ADDR_WD+DEV_ID_WD-1:DEV_ADDR_WD], offset below
PrWD  in  DATA_WD  write data
PrRD  out  DATA_WD  read data, valid while PrAck=1
PrAck  out  1  one-cycle completion pulse
PrErr  out  1  valid with PrAck; 1=decode error or timeout
DevAddr  out  DEV_ADDR_WD  latched offset
DevWD  out  DATA_WD  latched write data
DevSel  out  DEV_COUNT  one-hot select
DevWE  out  DEV_COUNT  one-hot write enable (subset of DevSel)
DevRD  in  DEV_COUNT*DATA_WD  flattened read data, device i at [i*DATA_WD +: DATA_WD]
DevReady  in  DEV_COUNT  per-device completion
DevIrq  in  DEV_COUNT  level interrupt requests
HWInt  out  DEV_COUNT  DevIrq registered one stage

Behaviour:
- Reset (synchronous, active-high) forces IDLE. All outputs are 0 after the reset edge: PrRD, PrAck, PrErr, DevAddr, DevWD, DevSel, DevWE, HWInt. Reset mid-transaction drops DevSel/DevWE at that edge, with no ack.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE, PrReq=0: stay.
- IDLE, PrReq=1, decode valid: latch offset/PrWD/PrWE/id. Next state ACCESS. DevSel[id]=1 and DevWE[id]=PrWE registered for ACCESS.
- Decode valid means PrAddr[31:DEV_ADDR_WD+DEV_ID_WD]==0 and id<DEV_COUNT. Otherwise next state is ERR.
- ACCESS: hold DevSel/DevWE/DevAddr/DevWD stable.
  - DevReady[id]=1: capture DevRD slice id into PrRD (writes capture 0). Drop DevSel/DevWE. Next state DONE.
  - DevReady of non-selected devices is ignored.
- DONE: PrAck=1, PrErr=0 for exactly one cycle, then IDLE.
- ERR: PrAck=1, PrErr=1, PrRD=0 for one cycle, then IDLE. No device is selected.
- Latency:
  - Ready in the first ACCESS cycle: PrAck two edges after the request is sampled.
  - Decode error: PrAck one edge after the request is sampled.
- The master deasserts PrReq on the edge where it sees PrAck. If PrReq is still high in the following IDLE cycle, it is a new transaction (back-to-back permitted, min 3-cycle period).
- PrAddr/PrWD changes during ACCESS have no effect (latched).
- HWInt <= DevIrq every cycle, independent of FSM.

Optional Feature:
BRIDGE_TIMEOUT_EN.
- Defined: counter clears on entering ACCESS and increments each ACCESS cycle without ready. After TIMEOUT cycles without ready, DevSel/DevWE drop and the FSM goes to ERR (PrAck=1, PrErr=1, PrRD=0). Ready in the same cycle the count reaches TIMEOUT wins (normal DONE).
- Undefined: ACCESS waits indefinitely; no counter logic; PrErr only from decode errors.

Test Plan:
- Read dev1: PrAddr=32'h0000_0145, PrWE=0, DevRD[1]=32'h8765_fedc, DevReady[1]=1 immediately -> DevSel=3'b010, DevAddr=8'h45; PrAck two edges later with PrRD=32'h8765_fedc, PrErr=0.
- Write dev2: PrAddr=32'h0000_027e, PrWD=32'hfedc_4321, PrWE=1, DevReady[2] delayed 3 cycles -> DevWE=3'b100, DevWD=32'hfedc_4321 held 4 cycles, single PrAck pulse.
- Decode error: PrAddr=32'h0000_0510 (id 5 >= 3) and PrAddr=32'h0001_0045 -> PrAck=1, PrErr=1, PrRD=0 after one edge; DevSel stays 0.
- Back-to-back: PrReq held high across two reads (dev0 offset 8'h10 ready=1, then dev1) -> two PrAck pulses 3 cycles apart, correct PrRD each.
- Reset mid-ACCESS: reset=1 while DevSel=3'b001 and no ready -> all outputs 0 next edge, no PrAck; a subsequent request completes normally.
- BRIDGE_TIMEOUT_EN, TIMEOUT=16: dev0 never ready -> PrAck=1, PrErr=1 after ACCESS has lasted 16 cycles. Repeat with ready on cycle 16 -> PrErr=0. DevIrq=3'b101 -> HWInt=3'b101 one edge later.
